// File: rtl/scan_pkg.sv
// Shared types and line levels for the scan unload transmitter and its paired receiver.
package scan_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } scan_state_t;

  localparam logic SO_IDLE  = 1'b1;
  localparam logic SO_START = 1'b0;

endpackage

// File: rtl/scan_unload_tx_if.sv
// Parallel word handshake plus serial scan-out signals between capture bank and transmitter.
interface scan_unload_tx_if #(
  parameter int unsigned WIDTH = 8
);

  logic [WIDTH-1:0] DIN;
  logic             DIN_VALID;
  logic             DIN_READY;
  logic             SO;
  logic             SO_ACTIVE;
  logic             DONE;

  modport master (
    output DIN, DIN_VALID,
    input  DIN_READY, SO, SO_ACTIVE, DONE
  );

  modport slave (
    input  DIN, DIN_VALID,
    output DIN_READY, SO, SO_ACTIVE, DONE
  );

endinterface

// File: rtl/scan_bit_timer.sv
// Serial bit-period divider: counts 0..BIT_DIV-1 while running and flags the wrap cycle.
module scan_bit_timer #(
  parameter int unsigned BIT_DIV = 1
) (
  input  logic clk,
  input  logic r,
  input  logic run,
  output logic wrap_c,
  output logic wrap_nxt_c
);

  localparam int unsigned CW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BIT_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_nxt;

  assign wrap_c = (cnt_q == LAST);

  always_comb begin
    cnt_nxt = '0;
    if (run && !wrap_c) begin
      cnt_nxt = cnt_q + CW'(1);
    end
  end

  // Lets the parent register outputs that depend on next cycle's wrap.
  assign wrap_nxt_c = (cnt_nxt == LAST);

  always_ff @(posedge clk) begin
    if (r) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_nxt;
    end
  end

endmodule

// File: rtl/scan_unload_tx.sv
// Framed serial transmitter: start, WIDTH data bits LSB first, optional even parity, stop.
// Parity bit is present when SCAN_UNLOAD_PARITY_EN is defined.
module scan_unload_tx
  import scan_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned BIT_DIV = 1
) (
  input  logic             CLK,
  input  logic             R,
  scan_unload_tx_if.slave  bus
);

  localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  scan_state_t      state_q, state_nxt;
  logic [WIDTH-1:0] shreg_q, shreg_nxt;
  logic [BW-1:0]    bitcnt_q, bitcnt_nxt;
  logic             so_q, so_nxt;
  logic             act_q, act_nxt;
  logic             done_q, done_nxt;
  logic             rdy_q, rdy_nxt;
  logic             wrap_c;
  logic             wrap_nxt_c;
  logic             accept_c;
`ifdef SCAN_UNLOAD_PARITY_EN
  logic             par_q, par_nxt;
`endif

  scan_bit_timer #(.BIT_DIV(BIT_DIV)) u_timer (
    .clk        (CLK),
    .r          (R),
    .run        (state_q != IDLE),
    .wrap_c     (wrap_c),
    .wrap_nxt_c (wrap_nxt_c)
  );

  assign accept_c = bus.DIN_VALID && (state_q == IDLE);

  // Next state and next register values; outputs are decoded from the next state
  // so every pin is a flop output.
  always_comb begin
    state_nxt  = state_q;
    shreg_nxt  = shreg_q;
    bitcnt_nxt = bitcnt_q;
`ifdef SCAN_UNLOAD_PARITY_EN
    par_nxt    = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          shreg_nxt = bus.DIN;
`ifdef SCAN_UNLOAD_PARITY_EN
          par_nxt   = ^bus.DIN;
`endif
          state_nxt = START;
        end
      end
      START: begin
        if (wrap_c) state_nxt = DATA;
      end
      DATA: begin
        if (wrap_c) begin
          shreg_nxt = shreg_q >> 1;
          if (bitcnt_q == BIT_LAST) begin
            bitcnt_nxt = '0;
`ifdef SCAN_UNLOAD_PARITY_EN
            state_nxt  = PARITY;
`else
            state_nxt  = STOP;
`endif
          end else begin
            bitcnt_nxt = bitcnt_q + BW'(1);
          end
        end
      end
`ifdef SCAN_UNLOAD_PARITY_EN
      PARITY: begin
        if (wrap_c) state_nxt = STOP;
      end
`endif
      STOP: begin
        if (wrap_c) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    so_nxt = SO_IDLE;
    case (state_nxt)
      START:   so_nxt = SO_START;
      DATA:    so_nxt = shreg_nxt[0];
`ifdef SCAN_UNLOAD_PARITY_EN
      PARITY:  so_nxt = par_nxt;
`endif
      default: so_nxt = SO_IDLE;
    endcase
    act_nxt  = (state_nxt != IDLE);
    rdy_nxt  = (state_nxt == IDLE);
    done_nxt = (state_nxt == STOP) && wrap_nxt_c;
  end

  always_ff @(posedge CLK) begin
    if (R) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      so_q     <= SO_IDLE;
      act_q    <= 1'b0;
      done_q   <= 1'b0;
      rdy_q    <= 1'b1;
`ifdef SCAN_UNLOAD_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_nxt;
      shreg_q  <= shreg_nxt;
      bitcnt_q <= bitcnt_nxt;
      so_q     <= so_nxt;
      act_q    <= act_nxt;
      done_q   <= done_nxt;
      rdy_q    <= rdy_nxt;
`ifdef SCAN_UNLOAD_PARITY_EN
      par_q    <= par_nxt;
`endif
    end
  end

  assign bus.SO        = so_q;
  assign bus.SO_ACTIVE = act_q;
  assign bus.DONE      = done_q;
  assign bus.DIN_READY = rdy_q;

endmodule

// File: tb/tb_scan_unload_tx.sv
// Directed bench for scan_unload_tx: one instance at BIT_DIV=1, one at BIT_DIV=4.
module tb_scan_unload_tx;

  logic clk;
  logic r;
  int   n_cmp;
  int   n_bad;

  scan_unload_tx_if #(.WIDTH(8)) b1 ();
  scan_unload_tx_if #(.WIDTH(8)) b4 ();

  scan_unload_tx #(.WIDTH(8), .BIT_DIV(1)) dut1 (.CLK(clk), .R(r), .bus(b1));
  scan_unload_tx #(.WIDTH(8), .BIT_DIV(4)) dut4 (.CLK(clk), .R(r), .bus(b4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected serial frame for an 8-bit word; returns its bit count.
  function automatic int build_frame(input logic [7:0] w, output logic [11:0] f);
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = w[i];
`ifdef SCAN_UNLOAD_PARITY_EN
    f[9]  = ^w;
    f[10] = 1'b1;
    return 11;
`else
    f[9] = 1'b1;
    return 10;
`endif
  endfunction

  // Tuples below are {SO, DONE, SO_ACTIVE, DIN_READY}.
  task automatic test_reset();
    logic [3:0] got1, got4;
    r = 1'b1;
    b1.DIN_VALID = 1'b0; b1.DIN = 8'h00;
    b4.DIN_VALID = 1'b0; b4.DIN = 8'h00;
    repeat (2) @(negedge clk);
    r = 1'b0;
    got1 = {b1.SO, b1.DONE, b1.SO_ACTIVE, b1.DIN_READY};
    got4 = {b4.SO, b4.DONE, b4.SO_ACTIVE, b4.DIN_READY};
    n_cmp++;
    if (got1 !== 4'b1001) begin
      n_bad++; $display("FAIL reset_div1: got %b expected %b", got1, 4'b1001);
    end
    n_cmp++;
    if (got4 !== 4'b1001) begin
      n_bad++; $display("FAIL reset_div4: got %b expected %b", got4, 4'b1001);
    end
  endtask

  task automatic test_idle_hold();
    logic [3:0] got;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      got = {b1.SO, b1.DONE, b1.SO_ACTIVE, b1.DIN_READY};
      n_cmp++;
      if (got !== 4'b1001) begin
        n_bad++; $display("FAIL idle_hold cyc %0d: got %b expected %b", i, got, 4'b1001);
      end
    end
  endtask

  task automatic test_frame_basic();
    logic [7:0]  words [2];
    logic [11:0] f;
    logic [3:0]  got, exp;
    int          nb;
    words[0] = 8'hA5;
    words[1] = 8'h07;
    for (int w = 0; w < 2; w++) begin
      nb = build_frame(words[w], f);
      b1.DIN = words[w];
      b1.DIN_VALID = 1'b1;
      @(negedge clk);
      b1.DIN_VALID = 1'b0;
      for (int i = 0; i < nb; i++) begin
        if (i > 0) @(negedge clk);
        got = {b1.SO, b1.DONE, b1.SO_ACTIVE, b1.DIN_READY};
        exp = {f[i], (i == nb - 1), 1'b1, 1'b0};
        n_cmp++;
        if (got !== exp) begin
          n_bad++;
          $display("FAIL frame_%h bit %0d: got %b expected %b", words[w], i, got, exp);
        end
      end
      @(negedge clk);
      got = {b1.SO, b1.DONE, b1.SO_ACTIVE, b1.DIN_READY};
      n_cmp++;
      if (got !== 4'b1001) begin
        n_bad++; $display("FAIL frame_%h after: got %b expected %b", words[w], got, 4'b1001);
      end
    end
  endtask

  task automatic test_bit_stretch();
    logic [11:0] f;
    logic [3:0]  got, exp;
    int          nb;
    int          cycles;
    nb = build_frame(8'h01, f);
    cycles = nb * 4;
    b4.DIN = 8'h01;
    b4.DIN_VALID = 1'b1;
    @(negedge clk);
    b4.DIN_VALID = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      if (i > 0) @(negedge clk);
      got = {b4.SO, b4.DONE, b4.SO_ACTIVE, b4.DIN_READY};
      exp = {f[i / 4], (i == cycles - 1), 1'b1, 1'b0};
      n_cmp++;
      if (got !== exp) begin
        n_bad++; $display("FAIL stretch cyc %0d: got %b expected %b", i, got, exp);
      end
    end
    @(negedge clk);
    got = {b4.SO, b4.DONE, b4.SO_ACTIVE, b4.DIN_READY};
    n_cmp++;
    if (got !== 4'b1001) begin
      n_bad++; $display("FAIL stretch after: got %b expected %b", got, 4'b1001);
    end
  endtask

  task automatic test_backpressure();
    logic [11:0] f;
    logic [3:0]  got, exp;
    int          nb;
    nb = build_frame(8'h3C, f);
    b1.DIN = 8'h3C;
    b1.DIN_VALID = 1'b1;
    @(negedge clk);
    for (int i = 0; i < nb; i++) begin
      if (i > 0) @(negedge clk);
      got = {b1.SO, b1.DONE, b1.SO_ACTIVE, b1.DIN_READY};
      exp = {f[i], (i == nb - 1), 1'b1, 1'b0};
      n_cmp++;
      if (got !== exp) begin
        n_bad++; $display("FAIL bp_frame bit %0d: got %b expected %b", i, got, exp);
      end
      b1.DIN = (i == nb - 1) ? 8'h5A : 8'($urandom);
    end
    // Gap cycle: ready is back, the held word is taken at the next edge.
    @(negedge clk);
    got = {b1.SO, b1.DONE, b1.SO_ACTIVE, b1.DIN_READY};
    n_cmp++;
    if (got !== 4'b1001) begin
      n_bad++; $display("FAIL bp_gap: got %b expected %b", got, 4'b1001);
    end
    nb = build_frame(8'h5A, f);
    @(negedge clk);
    b1.DIN_VALID = 1'b0;
    for (int i = 0; i < nb; i++) begin
      if (i > 0) @(negedge clk);
      got = {b1.SO, b1.DONE, b1.SO_ACTIVE, b1.DIN_READY};
      exp = {f[i], (i == nb - 1), 1'b1, 1'b0};
      n_cmp++;
      if (got !== exp) begin
        n_bad++; $display("FAIL bp_next bit %0d: got %b expected %b", i, got, exp);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    logic [11:0] f;
    logic [3:0]  got, exp;
    int          nb;
    nb = build_frame(8'hF0, f);
    b1.DIN = 8'hF0;
    b1.DIN_VALID = 1'b1;
    @(negedge clk);
    b1.DIN_VALID = 1'b0;
    for (int i = 0; i <= 4; i++) begin
      if (i > 0) @(negedge clk);
      got = {b1.SO, b1.DONE, b1.SO_ACTIVE, b1.DIN_READY};
      exp = {f[i], 1'b0, 1'b1, 1'b0};
      n_cmp++;
      if (got !== exp) begin
        n_bad++; $display("FAIL abort_pre bit %0d: got %b expected %b", i, got, exp);
      end
    end
    r = 1'b1;
    @(negedge clk);
    r = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      got = {b1.SO, b1.DONE, b1.SO_ACTIVE, b1.DIN_READY};
      n_cmp++;
      if (got !== 4'b1001) begin
        n_bad++; $display("FAIL abort_post cyc %0d: got %b expected %b", i, got, 4'b1001);
      end
    end
    nb = build_frame(8'h96, f);
    b1.DIN = 8'h96;
    b1.DIN_VALID = 1'b1;
    @(negedge clk);
    b1.DIN_VALID = 1'b0;
    for (int i = 0; i < nb; i++) begin
      if (i > 0) @(negedge clk);
      got = {b1.SO, b1.DONE, b1.SO_ACTIVE, b1.DIN_READY};
      exp = {f[i], (i == nb - 1), 1'b1, 1'b0};
      n_cmp++;
      if (got !== exp) begin
        n_bad++; $display("FAIL abort_new bit %0d: got %b expected %b", i, got, exp);
      end
    end
    @(negedge clk);
    got = {b1.SO, b1.DONE, b1.SO_ACTIVE, b1.DIN_READY};
    n_cmp++;
    if (got !== 4'b1001) begin
      n_bad++; $display("FAIL abort_new after: got %b expected %b", got, 4'b1001);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    r = 1'b1;
    b1.DIN = 8'h00; b1.DIN_VALID = 1'b0;
    b4.DIN = 8'h00; b4.DIN_VALID = 1'b0;
    test_reset();
    test_idle_hold();
    test_frame_basic();
    test_bit_stretch();
    test_backpressure();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/scan_unload_tx.md
Name: scan_unload_tx

Overview:
- Serial transmitter for the cell-level test and observation path.
- Takes a parallel word from a capture register and shifts it out as a framed bitstream on one wire.
- Frame is a start bit, WIDTH data bits LSB first, an optional even-parity bit, then a stop bit.
- It is the transmit end paired with the existing serial capture/deserializer side; it sits between the capture bank and the pad-level scan-out pin.

Parameters:
- WIDTH, 8, data bits per frame (range 1..64).
- BIT_DIV, 1, CLK cycles per serial bit (range 1..256).

Ports:
- CLK  input  1  single clock; all state updates on rising edge.
- R  input  1  reset; synchronous, active-high.
- DIN  input  WIDTH  parallel word to transmit.
- DIN_VALID  input  1  DIN holds a word to send.
- DIN_READY  output  1  block can accept a word this cycle.
- SO  output  1  serial data out; idles high.
- SO_ACTIVE  output  1  high while a frame is on SO, start bit through stop bit.
- DONE  output  1  one-cycle pulse in the final cycle of the stop bit.

Behaviour:
- Reset values (R high at a rising edge): state IDLE, SO=1, SO_ACTIVE=0, DONE=0, DIN_READY=1, shift register=0, counters=0.
- Handshake:
  - Accept occurs at the edge where DIN_VALID && DIN_READY.
  - DIN is latched into the shift register on that edge.
  - DIN_READY is high only in IDLE and is driven from state, with no combinational path from DIN_VALID.
- Framing: every bit, including start and stop, is held on SO for exactly BIT_DIV cycles. A div counter counts 0..BIT_DIV-1; a bit counter counts 0..WIDTH-1.
- State machine:
  - IDLE: SO=1. On accept, go to START.
  - START: SO=0. When the div counter wraps, go to DATA.
  - DATA: SO=shreg[0]. On div wrap, shift right; when the bit counter reaches WIDTH-1, go to PARITY if enabled, otherwise STOP.
  - PARITY: SO = XOR of the latched word (even parity). On div wrap, go to STOP.
  - STOP: SO=1. DONE=1 in its final cycle. On div wrap, go to IDLE.
- Latency: with the accept edge at cycle k, the start bit appears on SO from cycle k+1. Frame length is (WIDTH+2[+1 parity])*BIT_DIV cycles.
- SO_ACTIVE is high in START, DATA, PARITY and STOP.
- Back-to-back frames: DIN_READY returns high in the cycle after DONE. Minimum gap is one idle cycle with SO=1.
- DIN and DIN_VALID changing mid-frame have no effect; the word was latched at accept.
- Reset mid-frame: the frame is aborted, and SO=1, SO_ACTIVE=0 from the next cycle. No DONE is pulsed.
- R has priority over accept in the same cycle.
- All outputs are registered, so SO is glitch-free for a pad driver.

Optional Feature:
- Macro: SCAN_UNLOAD_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP.
  - SO carries even parity (XOR of the WIDTH data bits).
  - Frame length is (WIDTH+3)*BIT_DIV.
- When undefined:
  - No PARITY state and no parity logic.
  - DATA goes directly to STOP.
  - Frame length is (WIDTH+2)*BIT_DIV.

Decomposition:
- Shared package scan_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - the SO idle level constant (1'b1);
  - the start level constant (1'b0).
- The receiver side imports the same package.
- One natural sub-module: scan_bit_timer. It holds the div counter with a wrap pulse and is parameterised by BIT_DIV; it is reused by the receiver.

Test Plan:
- Basic frame: WIDTH=8, BIT_DIV=1, parity off. Accept DIN=8'hA5. From the next cycle SO = 0,1,0,1,0,0,1,0,1,1, with DONE on the 10th bit and DIN_READY=1 one cycle later.
- Parity on: same stimulus, DIN=8'hA5. The parity bit is 0 (four ones), the frame is 11 bits, and DONE is on bit 11. Then DIN=8'h07 gives parity bit 1.
- Bit stretching: BIT_DIV=4, DIN=8'h01. Start low for 4 cycles, data bit0 high for 4 cycles, bits 1..7 low for 28 cycles, stop high for 4 cycles. Total frame is 40 cycles.
- Backpressure: hold DIN_VALID=1 with changing DIN during a frame. DIN_READY stays 0, the frame transmits the word latched at accept, and the next word is accepted exactly one cycle after DONE.
- Reset mid-frame: assert R during data bit 3. From the next cycle SO=1, SO_ACTIVE=0, DIN_READY=1, and no DONE. A new accept then produces a clean full frame.
- Idle hold: DIN_VALID=0 for 50 cycles after reset. SO stays 1, SO_ACTIVE stays 0, and DONE never pulses.
